// File: rtl/onchip_memory_port_arbiter.sv
// Round-robin share of one on-chip memory port between a loader master (m0)
// and a debug master (m1); returned read data is routed back by a tag pipeline.
module onchip_memory_port_arbiter #(
  parameter int ADDR_W           = 10,
  parameter int DATA_W           = 32,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  localparam int TAG_D = MEM_READ_LATENCY + 1;

  logic             req0, req1;
  logic             grant0, grant1;
  logic             accept;
  logic             win_write;
  logic             rr;
  logic [TAG_D-1:0] tag_valid;
  logic [TAG_D-1:0] tag_id;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // rr names the master that wins a tie
  assign grant0 = req0 & (~req1 | ~rr);
  assign grant1 = req1 & (~req0 | rr);
  assign accept = grant0 | grant1;

  // read+write together is treated as a write
  assign win_write = grant1 ? m1_write : m0_write;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= 1'b0;
    end else if (accept) begin
      rr <= ~grant1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
    end else if (accept) begin
      mem_chipselect <= 1'b1;
      mem_write      <= win_write;
      mem_address    <= grant1 ? m1_address    : m0_address;
      mem_byteenable <= grant1 ? m1_byteenable : m0_byteenable;
      mem_writedata  <= grant1 ? m1_writedata  : m0_writedata;
    end else begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
    end
  end

  // Last stage lines up with the cycle the memory presents readdata
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[TAG_D-2:0], accept & ~win_write};
      tag_id    <= {tag_id[TAG_D-2:0], grant1};
    end
  end

  assign m0_readdatavalid = tag_valid[TAG_D-1] & ~tag_id[TAG_D-1];
  assign m1_readdatavalid = tag_valid[TAG_D-1] &  tag_id[TAG_D-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign mem_clken        = 1'b1;

endmodule
